avalon_mm_copy_master: RTL and testbench

- Avalon-MM initiator that copies a block of 32-bit words from a source region to a destination region.
- Target is any on-chip memory slave, such as onchip_memory2 instances, over the system interconnect.
- Issues single-word read/write transfers (no bursts), one word in flight, with a one-word holding buffer.
- Commanded by a start pulse from a control FSM or Nios II PIO; reports busy/done.

---
 rtl/avalon_mm_copy_master.sv | 104 ++++++++++
 tb/tb_avalon_mm_copy_master.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_mm_copy_master.sv
// Avalon-MM initiator that copies word_count 32-bit words from src to dst,
// one single-word read then write at a time through a one-word holding buffer.
module avalon_mm_copy_master #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] src, dst;
  logic [LEN_W-1:0]  remaining;
  logic [31:0]       buffer;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      src       <= '0;
      dst       <= '0;
      remaining <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        src       <= src_addr & ~ADDR_W'(3);
        dst       <= dst_addr & ~ADDR_W'(3);
        remaining <= word_count;
      end else if (state == WR_REQ && !avm_waitrequest) begin
        // Address wrap at the top of the space is intentional and silent.
        src       <= src + ADDR_W'(4);
        dst       <= dst + ADDR_W'(4);
        remaining <= remaining - LEN_W'(1);
      end
    end
  end

  // Holding buffer is pure data; it is gated off the bus outside WR_REQ.
  always_ff @(posedge clk) begin
    if (state == RD_WAIT && avm_readdatavalid) buffer <= avm_readdata;
  end

  always_comb begin
    state_nxt      = state;
    busy           = 1'b0;
    done           = 1'b0;
    avm_address    = '0;
    avm_read       = 1'b0;
    avm_write      = 1'b0;
    avm_byteenable = 4'h0;
    avm_writedata  = '0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (word_count == '0) ? DONE : RD_REQ;
      end
      RD_REQ: begin
        busy           = 1'b1;
        avm_read       = 1'b1;
        avm_address    = src;
        avm_byteenable = 4'hF;
        if (!avm_waitrequest) state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        busy = 1'b1;
        if (avm_readdatavalid) state_nxt = WR_REQ;
      end
      WR_REQ: begin
        busy           = 1'b1;
        avm_write      = 1'b1;
        avm_address    = dst;
        avm_writedata  = buffer;
        avm_byteenable = 4'hF;
        if (!avm_waitrequest) state_nxt = (remaining == LEN_W'(1)) ? DONE : RD_REQ;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_avalon_mm_copy_master.sv
// Randomized bench for avalon_mm_copy_master: a behavioural memory slave with
// random stalls/latency, and a sequential copy model predicting every transfer.
module tb_avalon_mm_copy_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] word_count;
  logic        busy, done;
  logic [31:0] avm_address;
  logic        avm_read, avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  avalon_mm_copy_master #(.ADDR_W(32), .LEN_W(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .word_count(word_count),
    .busy(busy), .done(done),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Memory contents: untouched words hold an address-derived pattern.
  logic [31:0] slave_mem [logic [31:0]];
  logic [31:0] ref_mem   [logic [31:0]];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [31:0] slave_rd(input logic [31:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  typedef struct {
    logic        is_write;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  xfer_t exp_q[$];

  int stall_pct = 0;
  int lat_max   = 1;

  // Slave: every decision is made at the falling edge and holds through the
  // following rising edge, where the DUT samples it.
  logic        pend_v = 1'b0;
  int          pend_due;
  logic [31:0] pend_data;
  logic        stalled = 1'b0;
  logic [31:0] h_addr, h_wdata;
  logic        h_rd, h_wr;

  always @(negedge clk) begin
    if (reset) begin
      pend_v            = 1'b0;
      stalled           = 1'b0;
      avm_waitrequest   = 1'b0;
      avm_readdatavalid = 1'b0;
    end else begin
      if (stalled) begin
        chk("hold_addr",  avm_address,   h_addr);
        chk("hold_read",  avm_read,      h_rd);
        chk("hold_write", avm_write,     h_wr);
        chk("hold_wdata", avm_writedata, h_wdata);
      end
      chk("rd_wr_excl", avm_read & avm_write, 1'b0);
      chk("byteenable", avm_byteenable, (avm_read | avm_write) ? 4'hF : 4'h0);

      if (pend_v && cyc == pend_due) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = pend_data;
        pend_v            = 1'b0;
      end else begin
        avm_readdatavalid = 1'b0;
        avm_readdata      = $urandom;
      end

      if (avm_read | avm_write)
        avm_waitrequest = ($urandom_range(99) < stall_pct);
      else
        avm_waitrequest = $urandom_range(1);

      if ((avm_read | avm_write) && !avm_waitrequest) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_xfer", 1'b1, 1'b0);
        end else begin
          xfer_t e;
          e = exp_q.pop_front();
          chk("xfer_kind", avm_write, e.is_write);
          chk("xfer_addr", avm_address, e.addr);
          if (e.is_write) chk("xfer_wdata", avm_writedata, e.data);
        end
        if (avm_write) begin
          slave_mem[avm_address] = avm_writedata;
        end else begin
          pend_v    = 1'b1;
          pend_due  = cyc + $urandom_range(lat_max, 1);
          pend_data = slave_rd(avm_address);
        end
      end

      stalled = (avm_read | avm_write) && avm_waitrequest;
      h_addr  = avm_address;
      h_rd    = avm_read;
      h_wr    = avm_write;
      h_wdata = avm_writedata;
    end
  end

  // Completion monitor.
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   busy_cyc = 0;
  int   start_cyc = 0;
  logic busy_seen = 1'b0;
  logic any_req = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (busy && !busy_seen) begin
        busy_seen = 1'b1;
        busy_cyc  = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_during_done", busy, 1'b0);
      end
      if (avm_read | avm_write) any_req = 1'b1;
    end
  end

  // Reference model: ascending word-by-word copy over the model memory.
  task automatic kick(input logic [31:0] s, input logic [31:0] d, input int n);
    logic [31:0] sa, da, v;
    sa = s & ~32'd3;
    da = d & ~32'd3;
    for (int i = 0; i < n; i++) begin
      v = ref_rd(sa + 32'(4 * i));
      exp_q.push_back('{1'b0, sa + 32'(4 * i), 32'h0});
      exp_q.push_back('{1'b1, da + 32'(4 * i), v});
      ref_mem[da + 32'(4 * i)] = v;
    end
    @(negedge clk);
    done_cnt   = 0;
    busy_seen  = 1'b0;
    any_req    = 1'b0;
    src_addr   = s;
    dst_addr   = d;
    word_count = 16'(n);
    start      = 1'b1;
    start_cyc  = cyc;
    @(negedge clk);
    start      = 1'b0;
    src_addr   = $urandom;
    dst_addr   = $urandom;
    word_count = 16'($urandom);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, (n < 3000), 1'b1);
    repeat (3) @(negedge clk);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_xfers_left"}, exp_q.size(), 0);
  endtask

  task automatic check_dst(input string tag, input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++)
      chk({tag, "_dst"}, slave_rd((d & ~32'd3) + 32'(4 * i)), ref_rd((d & ~32'd3) + 32'(4 * i)));
  endtask

  initial begin
    reset             = 1'b1;
    start             = 1'b0;
    src_addr          = '0;
    dst_addr          = '0;
    word_count        = '0;
    avm_waitrequest   = 1'b0;
    avm_readdata      = '0;
    avm_readdatavalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {busy, done, avm_read, avm_write, avm_byteenable, (avm_address != 0), (avm_writedata != 0)},
        '0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic 4-word copy, no stalls, latency 1.
    stall_pct = 0; lat_max = 1;
    kick(32'h0000, 32'h0100, 4);
    wait_done("basic");
    chk("basic_done_after_busy", done_cyc - busy_cyc, 12);
    check_dst("basic", 32'h0100, 4);

    // Zero-length command.
    kick(32'h1000, 32'h2000, 0);
    wait_done("zero");
    chk("zero_no_request", any_req, 1'b0);
    chk("zero_busy_never", busy_seen, 1'b0);
    chk("zero_done_latency", done_cyc - start_cyc, 1);

    // Stalled reads and writes with variable read latency.
    stall_pct = 50; lat_max = 3;
    kick(32'h0400, 32'h0800, 8);
    wait_done("stall");
    check_dst("stall", 32'h0800, 8);

    // Unaligned source and a second start issued mid-copy.
    kick(32'h0203, 32'h3001, 2);
    repeat (3) @(negedge clk);
    src_addr = 32'h9000; dst_addr = 32'hA000; word_count = 16'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("unaligned");
    check_dst("unaligned", 32'h3000, 2);

    // Abort by reset during the second write of five.
    begin
      int n, wr_seen;
      stall_pct = 0; lat_max = 1;
      kick(32'h7000, 32'h7800, 5);
      n = 0; wr_seen = 0;
      while (wr_seen < 2 && n < 200) begin
        if (avm_write) wr_seen++;
        if (wr_seen < 2) begin
          @(negedge clk);
          n++;
        end
      end
      chk("abort_reach_write2", (n < 200), 1'b1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_write", avm_write, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      repeat (4) @(negedge clk);
      chk("abort_no_done", done_cnt, 0);
      exp_q.delete();
      kick(32'h7100, 32'h7900, 1);
      wait_done("after_abort");
      check_dst("after_abort", 32'h7900, 1);
    end

    // Source address wraps past the top of the space.
    stall_pct = 30; lat_max = 2;
    kick(32'hFFFF_FFFC, 32'h5000, 2);
    wait_done("wrap");
    check_dst("wrap", 32'h5000, 2);

    // Random copies, overlapping regions included.
    stall_pct = 50; lat_max = 3;
    for (int t = 0; t < 6; t++) begin
      logic [31:0] s, d;
      int n;
      s = 32'($urandom_range(32'h3FF)) << 2;
      d = 32'($urandom_range(32'h3FF)) << 2;
      n = $urandom_range(6, 1);
      kick(s, d, n);
      wait_done("random");
      check_dst("random", d, n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
